// File: rtl/seq_calculator.sv
// seq_calculator
//   Width-generic sequential arithmetic engine with a start/done handshake.
//   Add/subtract finish in one EXEC cycle, multiply is a shift-add loop
//   (multiplier LSB first), divide is a restoring loop (dividend MSB first),
//   each W iterations. One trailing FIN cycle precedes the done pulse.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active high
//   start_i        request, accepted only while busy_o = 0
//   op_i           00 add, 01 sub, 10 div, 11 mul
//   a_i, b_i       unsigned operands (a = dividend/minuend, b = divisor/subtrahend)
//   busy_o         operation in progress
//   done_o         one-cycle pulse, outputs valid from this cycle on
//   result_o       2W-bit sum / difference / product / zero-extended quotient
//   remainder_o    divide remainder, 0 otherwise
//   neg_o          subtract with a < b
//   div_by_zero_o  divide with b = 0
//   bcd_o          BCD of |result| (only with CALC_BCD_EN)
//
// Optional feature: define CALC_BCD_EN to add a double-dabble CONV phase
// (2W cycles) and the bcd_o port.
//
// States
//   IDLE | waiting for start_i (also the done-pulse cycle)
//   EXEC | arithmetic, iterated for mul/div
//   CONV | binary to BCD, one bit per cycle (CALC_BCD_EN only)
//   FIN  | last busy cycle, done pulses on the following cycle
module seq_calculator #(
    parameter int W      = 4,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [W-1:0]          a_i,
    input  logic [W-1:0]          b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2*W-1:0]        result_o,
    output logic [W-1:0]          remainder_o,
    output logic                  neg_o,
`ifdef CALC_BCD_EN
    output logic [4*DIGITS-1:0]   bcd_o,
`endif
    output logic                  div_by_zero_o
);

    localparam int CW = $clog2(W + 1);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

`ifdef CALC_BCD_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CONV, S_FIN} state_t;
    localparam int CCW = $clog2(2 * W + 1);
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FIN} state_t;
`endif

    state_t             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               neg_q, neg_d, dbz_q, dbz_d;
    logic [2*W-1:0]     result_q, result_d;
    logic [W-1:0]       rem_q, rem_d;
    logic [1:0]         op_q, op_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // mul: acc = partial product, mcand = a shifted left, mplier = b shifted right
    // div: acc = quotient shifted in, mplier = dividend shifted left, prem = partial remainder
    logic [2*W-1:0]     acc_q, acc_d, mcand_q, mcand_d;
    logic [W-1:0]       mplier_q, mplier_d, prem_q, prem_d;
    logic [W:0]         trial;
    logic               qbit, exec_last;
`ifdef CALC_BCD_EN
    logic [CCW-1:0]     ccnt_q, ccnt_d;
    logic [2*W-1:0]     bin_q, bin_d;
    logic [4*DIGITS-1:0] bcdw_q, bcdw_d, bcd_q, bcd_d, work;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prem_q   <= '0;
`ifdef CALC_BCD_EN
            ccnt_q   <= '0;
            bin_q    <= '0;
            bcdw_q   <= '0;
            bcd_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            neg_q    <= neg_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prem_q   <= prem_d;
`ifdef CALC_BCD_EN
            ccnt_q   <= ccnt_d;
            bin_q    <= bin_d;
            bcdw_q   <= bcdw_d;
            bcd_q    <= bcd_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        neg_d     = neg_q;
        dbz_d     = dbz_q;
        result_d  = result_q;
        rem_d     = rem_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prem_d    = prem_q;
        trial     = '0;
        qbit      = 1'b0;
        exec_last = 1'b0;
`ifdef CALC_BCD_EN
        ccnt_d    = ccnt_q;
        bin_d     = bin_q;
        bcdw_d    = bcdw_q;
        bcd_d     = bcd_q;
        work      = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d     = op_i;
                    a_d      = a_i;
                    b_d      = b_i;
                    neg_d    = 1'b0;
                    dbz_d    = 1'b0;
                    rem_d    = '0;
                    cnt_d    = '0;
                    acc_d    = '0;
                    prem_d   = '0;
                    mcand_d  = {{W{1'b0}}, a_i};
                    mplier_d = (op_i == OP_DIV) ? a_i : b_i;
                    busy_d   = 1'b1;
                    state_d  = S_EXEC;
`ifdef CALC_BCD_EN
                    bcd_d    = '0;
`endif
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        result_d  = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
                        exec_last = 1'b1;
                    end
                    OP_SUB: begin
                        // 2W-bit wraparound gives the sign extension for free
                        result_d  = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
                        neg_d     = (a_q < b_q);
                        exec_last = 1'b1;
                    end
                    OP_MUL: begin
                        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        if (cnt_q == CW'(W - 1)) begin
                            result_d  = acc_d;
                            exec_last = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    OP_DIV: begin
                        if (b_q == '0) begin
                            result_d  = {{W{1'b0}}, {W{1'b1}}};
                            rem_d     = a_q;
                            dbz_d     = 1'b1;
                            exec_last = 1'b1;
                        end else begin
                            trial    = {prem_q, mplier_q[W-1]};
                            qbit     = (trial >= {1'b0, b_q});
                            // a restored remainder is below b, so W bits suffice
                            prem_d   = qbit ? (trial[W-1:0] - b_q) : trial[W-1:0];
                            acc_d    = {acc_q[2*W-2:0], qbit};
                            mplier_d = mplier_q << 1;
                            if (cnt_q == CW'(W - 1)) begin
                                result_d  = {{W{1'b0}}, acc_d[W-1:0]};
                                rem_d     = prem_d;
                                exec_last = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                    end
                endcase
                if (exec_last) begin
`ifdef CALC_BCD_EN
                    bin_d   = neg_d ? (~result_d + {{(2*W-1){1'b0}}, 1'b1}) : result_d;
                    bcdw_d  = '0;
                    ccnt_d  = '0;
                    state_d = S_CONV;
`else
                    state_d = S_FIN;
`endif
                end
            end
`ifdef CALC_BCD_EN
            S_CONV: begin
                work = bcdw_q;
                for (int i = 0; i < DIGITS; i++) begin
                    if (work[4*i +: 4] >= 4'd5) work[4*i +: 4] = work[4*i +: 4] + 4'd3;
                end
                bcdw_d = {work[4*DIGITS-2:0], bin_q[2*W-1]};
                bin_d  = bin_q << 1;
                if (ccnt_q == CCW'(2 * W - 1)) begin
                    bcd_d   = bcdw_d;
                    state_d = S_FIN;
                end else begin
                    ccnt_d = ccnt_q + CCW'(1);
                end
            end
`endif
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign remainder_o   = rem_q;
    assign neg_o         = neg_q;
    assign div_by_zero_o = dbz_q;
`ifdef CALC_BCD_EN
    assign bcd_o         = bcd_q;
`endif

endmodule

// File: tb/tb_seq_calculator.sv
module tb_seq_calculator;

    localparam int W = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [1:0]        op_i;
    logic [W-1:0]      a_i, b_i;
    logic              busy_o, done_o, neg_o, div_by_zero_o;
    logic [2*W-1:0]    result_o;
    logic [W-1:0]      remainder_o;
`ifdef CALC_BCD_EN
    logic [11:0]       bcd_o;
`endif

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] prev_res;

    seq_calculator #(.W(W), .DIGITS(3)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .op_i          (op_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .result_o      (result_o),
        .remainder_o   (remainder_o),
        .neg_o         (neg_o),
`ifdef CALC_BCD_EN
        .bcd_o         (bcd_o),
`endif
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the arithmetic rules, independent of how the loops iterate.
    task automatic model(input logic [1:0] op, input int a, input int b,
                         output logic [2*W-1:0] res, output logic [W-1:0] rem,
                         output logic ng, output logic dz, output int lat);
        int mask;
        mask = (1 << (2 * W)) - 1;
        rem  = '0;
        ng   = 1'b0;
        dz   = 1'b0;
        lat  = 2;
        case (op)
            2'b00: res = (2*W)'(a + b);
            2'b01: begin
                res = (2*W)'((a - b) & mask);
                ng  = (a < b);
            end
            2'b11: begin
                res = (2*W)'(a * b);
                lat = W + 1;
            end
            default: begin
                if (b == 0) begin
                    res = (2*W)'((1 << W) - 1);
                    rem = W'(a);
                    dz  = 1'b1;
                end else begin
                    res = (2*W)'(a / b);
                    rem = W'(a % b);
                    lat = W + 1;
                end
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic do_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int poke_j);
        logic [2*W-1:0] e_res;
        logic [W-1:0]   e_rem;
        logic           e_neg, e_dz;
        int lat, busy_n, hold_bad, done_at;
        model(op, int'(a), int'(b), e_res, e_rem, e_neg, e_dz, lat);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom); op_i = 2'($urandom);
        busy_n = 0; hold_bad = 0; done_at = -1;
        for (int j = 0; j < lat + 4; j++) begin
            if (j > 0) @(negedge clk_i);
            start_i = (j == poke_j);
            if (j == poke_j) op_i = 2'b00;
            if (done_o) begin
                done_at = j;
                break;
            end
            if (busy_o) busy_n++;
            if (j < lat - 1) begin
                if (result_o !== prev_res) hold_bad++;
                if (neg_o || div_by_zero_o || remainder_o != '0) hold_bad++;
            end
        end
        start_i = 1'b0;
        chk({nm, ".done_lat"}, 32'(done_at), 32'(lat));
        chk({nm, ".busy_cycles"}, 32'(busy_n), 32'(lat));
        chk({nm, ".interm"}, 32'(hold_bad), 32'd0);
        chk({nm, ".busy_at_done"}, 32'(busy_o), 32'd0);
        chk({nm, ".result"}, 32'(result_o), 32'(e_res));
        chk({nm, ".rem"}, 32'(remainder_o), 32'(e_rem));
        chk({nm, ".neg"}, 32'(neg_o), 32'(e_neg));
        chk({nm, ".dbz"}, 32'(div_by_zero_o), 32'(e_dz));
        prev_res = e_res;
    endtask

    task automatic idle_check(input string nm);
        @(negedge clk_i);
        chk({nm, ".done_pulse"}, 32'(done_o), 32'd0);
        chk({nm, ".held"}, 32'(result_o), 32'(prev_res));
    endtask

    task automatic reset_mid_div();
        int seen;
        op_i = 2'b10; a_i = 4'd13; b_i = 4'd3; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("rst_abort", 32'({busy_o, done_o, neg_o, div_by_zero_o, remainder_o, result_o}), 32'd0);
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            if (done_o) seen++;
        end
        rst_i = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk_i);
            if (done_o || busy_o) seen++;
        end
        chk("rst_no_done", 32'(seen), 32'd0);
        prev_res = '0;
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        rst_i = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        prev_res = '0;
        #1;
        chk("reset_outputs", 32'({busy_o, done_o, neg_o, div_by_zero_o, remainder_o, result_o}), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        do_op("add_9_7", 2'b00, 4'd9, 4'd7, -1);
        idle_check("add_9_7");
        do_op("sub_3_5", 2'b01, 4'd3, 4'd5, -1);
        idle_check("sub_3_5");
        do_op("mul_15_15", 2'b11, 4'd15, 4'd15, -1);
        idle_check("mul_15_15");
        do_op("div_13_4", 2'b10, 4'd13, 4'd4, -1);
        idle_check("div_13_4");
        do_op("div_13_0", 2'b10, 4'd13, 4'd0, -1);
        idle_check("div_13_0");
        do_op("mul_6_7_poke", 2'b11, 4'd6, 4'd7, 1);
        do_op("b2b_sub", 2'b01, 4'd12, 4'd2, -1);
        do_op("b2b_div", 2'b10, 4'd15, 4'd15, -1);
        idle_check("b2b_div");

        reset_mid_div();
        do_op("after_rst", 2'b10, 4'd14, 4'd5, -1);
        idle_check("after_rst");

        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom);
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            do_op("rand", rop, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1);
            if ($urandom_range(0, 1) == 1) idle_check("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_calculator.md
# seq_calculator

Parametrised, multi-cycle arithmetic core that takes two unsigned W-bit operands and an opcode and returns a 2W-bit result through a start/done handshake. Add and subtract complete in one cycle. Multiply uses a shift-add loop and divide uses a restoring loop, each taking W iterations. The block sits between the switch/button front end and the BCD/seven-segment display path, and replaces fixed 4-bit single-cycle arithmetic with a width-generic sequential engine.

## Interface
- `W`, default 4: operand width; must be ≥ 2.
- `DIGITS`, default 3: BCD digit count, used only with `CALC_BCD_EN`. Must satisfy 10^DIGITS > 2^(2W)−1.
- `clk` in, 1: single clock. All state changes on the rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `start` in, 1: request. Sampled only while `busy`=0.
- `op` in, 2: 00 add, 01 subtract, 10 divide, 11 multiply.
- `a` in, W: operand A (dividend / minuend). Unsigned.
- `b` in, W: operand B (divisor / subtrahend). Unsigned.
- `busy` out, 1: operation in progress.
- `done` out, 1: one-cycle pulse; results are valid from this cycle on.
- `result` out, 2W: sum, difference, product or zero-extended quotient.
- `remainder` out, W: divide remainder; 0 for other ops.
- `neg` out, 1: subtract with a<b.
- `div_by_zero` out, 1: divide with b=0.
- `bcd` out, 4·DIGITS: present only with `CALC_BCD_EN`; BCD of |result|.

## Operation
- States: IDLE, EXEC, CONV (only with `CALC_BCD_EN`), FIN.
- IDLE, `start`=1:
  - `a`, `b`, `op` are latched.
  - `neg`, `div_by_zero`, `remainder` and (with `CALC_BCD_EN`) `bcd` are cleared.
  - `busy` goes to 1; `result` is not cleared and holds its previous value until the next write.
  - Next state is EXEC.
- Operand pins are ignored after the accepting edge.
- EXEC, add: `result` = a+b, zero-extended. Go to FIN next edge.
- EXEC, subtract: `result` = a−b, computed in 2W-bit two's complement and sign-extended; `neg` = (a<b). Go to FIN next edge.
- EXEC, multiply: one shift-add step per cycle over W cycles, LSB of multiplier first. After the final step, `result` = a·b (never overflows 2W). Go to FIN.
- EXEC, divide, b≠0: one restoring step per cycle over W cycles, MSB first. `result[W-1:0]` = ⌊a/b⌋, upper W bits 0, `remainder` = a mod b. Go to FIN.
- EXEC, divide, b=0: no iterations. `result` = {W'b0, W{1'b1}}, `remainder` = a, `div_by_zero` = 1. Go to FIN on the next edge.
- FIN: `done` = 1 and `busy` = 0 for exactly one cycle, then return to IDLE.
  - A `start` seen during FIN is accepted as if in IDLE, giving back-to-back operations.
- All outputs hold their last values until the next accepted `start`.
- `start` while `busy`=1 is ignored; no queueing.
- Intermediate partial products and quotients are never visible on `result`; it updates only on the final EXEC edge.

## Timing
- Reset (asynchronous): state IDLE; `busy`, `done`, `neg`, `div_by_zero` = 0; `result`, `remainder`, `bcd` = 0; iteration counter = 0.
- Reset mid-operation aborts immediately with the same values. No `done` is produced for the aborted op.
- Latency L is counted from the accepting edge k; `done` is high in the cycle following edge k+L:
  - add / subtract / divide-by-zero: L = 2
  - multiply / divide: L = W+1
  - with `CALC_BCD_EN`: L += 2W
- `busy` is high in the cycles following edges k through k+L−1.
- Iteration counter is ⌈log2(W+1)⌉ bits wide, counts 0..W−1, and clears on entering EXEC.

## Configuration
- Macro: `CALC_BCD_EN`.
- Defined:
  - After EXEC the FSM enters CONV and runs a sequential double-dabble on |result| (magnitude of the 2W-bit two's-complement value when `neg`=1).
  - One bit per cycle, 2W cycles, then FIN.
  - `bcd` updates on the last CONV edge; digit 0 is in bits [3:0].
- Undefined: no `bcd` port, no CONV state, latencies as listed without the added 2W.

## Test plan
- W=4, op=00, a=9, b=7 → `done` in the cycle after edge k+2; `result`=0x10; `neg`=0; `busy` high for exactly 2 cycles.
- W=4, op=01, a=3, b=5 → `result`=0xFE, `neg`=1. With `CALC_BCD_EN`: `bcd`=0x002 and `done` in the cycle after edge k+10.
- W=4, op=11, a=15, b=15 → `result`=0xE1 (225) in the cycle after edge k+5. With `CALC_BCD_EN`: `bcd`=0x225. Then W=8, a=255, b=255 → `result`=0xFE01.
- W=4, op=10:
  - a=13, b=4 → `result`=0x03, `remainder`=1.
  - a=13, b=0 → `result`=0x0F, `remainder`=13, `div_by_zero`=1, L=2.
- W=4, start multiply 6·7; pulse `start` with op=00 at EXEC cycle 2 → second `start` ignored and `result`=42. Start a new op in the FIN cycle → accepted back-to-back.
- Assert `rst` during divide iteration 2 → all outputs 0 immediately, no `done`. A new op after release completes correctly.
